// File: rtl/host_output_transmit_pkg.sv
// Host-side shared constants for the host output transmit path.
// Contents:
//   - default widths/latencies for the transmit block
//   - buffer word flag encodings carried in bits [133:132]
//   - FSM state type used by host_output_transmit (also exported for debug)
package host_output_transmit_pkg;

    localparam int DEF_BUFID_W    = 9;
    localparam int DEF_LINE_W     = 4;
    localparam int DEF_DATA_W     = 134;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_IFG_CYCLES = 3;
    localparam int DESC_W         = 13;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;
    localparam logic [1:0] FLAG_INV  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_GAP     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/host_rd_lat_pipe.sv
// Read-latency tag pipe: follows each packet RAM read through the fixed RAM
// latency so the returning word can be identified (valid + line index).
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_issue          a read is being issued this cycle
//   iv_issue_tag     tag (line index) of that read
//   i_flush          discard every read still in flight
//   o_ret_valid      RAM data on the bus this cycle belongs to a live read
//   ov_ret_tag       tag of that returning read
module host_rd_lat_pipe #(
    parameter int RD_LAT = 2,
    parameter int TAG_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue,
    input  logic [TAG_W-1:0] iv_issue_tag,
    input  logic             i_flush,
    output logic             o_ret_valid,
    output logic [TAG_W-1:0] ov_ret_tag
);

    logic [RD_LAT-1:0] r_vld;
    logic [TAG_W-1:0]  r_tag [RD_LAT];

    // Valid bits are cleared by flush; tags just shift, they are only
    // meaningful alongside a set valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (i_flush) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= i_issue;
                for (int i = 1; i < RD_LAT; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
            r_tag[0] <= iv_issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_ret_valid = r_vld[RD_LAT-1];
    assign ov_ret_tag  = r_tag[RD_LAT-1];

endmodule

// File: rtl/host_output_transmit.sv
// Host output transmit: takes one descriptor, reads the packet line by line
// from the packet buffer, streams the words to the host, releases the
// buffer id, then pulses o_host_outport_free for the next descriptor.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   iv_descriptor, i_descriptor_wr  descriptor strobe from the scheduler
//   o_host_outport_free             1-cycle "ready for next descriptor"
//   ov_pkt_raddr, o_pkt_rd          packet RAM read {bufid, line}
//   iv_pkt_rdata                    RAM data, RD_LAT cycles after o_pkt_rd
//   ov_data, o_data_wr              words to the host (registered)
//   ov_pkt_bufid, o_pkt_bufid_wr    release request, held until
//   i_pkt_bufid_ack                 the buffer manager acknowledges it
//   ov_hot_state                    FSM state (IDLE/READ/GAP/RELEASE)
//   ov_debug_pkt_cnt                packets completed (wraps)
//   ov_debug_err_cnt                truncations + dropped descriptors (saturates)
// Handshake: o_pkt_bufid_wr is a level request; a transfer happens on a
// cycle where o_pkt_bufid_wr and i_pkt_bufid_ack are both high, and the
// request drops on the following cycle.
module host_output_transmit
    import host_output_transmit_pkg::*;
#(
    parameter int BUFID_W    = DEF_BUFID_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DESC_W-1:0]         iv_descriptor,
    input  logic                      i_descriptor_wr,
    output logic                      o_host_outport_free,
    output logic [BUFID_W+LINE_W-1:0] ov_pkt_raddr,
    output logic                      o_pkt_rd,
    input  logic [DATA_W-1:0]         iv_pkt_rdata,
    output logic [DATA_W-1:0]         ov_data,
    output logic                      o_data_wr,
    output logic [BUFID_W-1:0]        ov_pkt_bufid,
    output logic                      o_pkt_bufid_wr,
    input  logic                      i_pkt_bufid_ack,
    output logic [1:0]                ov_hot_state,
    output logic [15:0]               ov_debug_pkt_cnt,
    output logic [15:0]               ov_debug_err_cnt
);

    localparam int GAP_W    = 8;
    localparam int GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    state_t               r_state;
    state_t               w_next_state;
    logic [BUFID_W-1:0]   r_bufid;
    logic [LINE_W-1:0]    r_line;
    logic                 r_all_issued;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_free;
    logic [DATA_W-1:0]    r_data;
    logic                 r_data_wr;
    logic [15:0]          r_pkt_cnt;
    logic [15:0]          r_err_cnt;

    logic                 w_rd;
    logic                 w_ret_valid;
    logic [LINE_W-1:0]    w_ret_line;
    logic [1:0]           w_ret_flag;
    logic                 w_last_line;
    logic                 w_done;
    logic                 w_trunc;
    logic                 w_desc_take;
    logic                 w_desc_drop;
    logic                 w_ack;
    logic [1:0]           w_err_inc;
    logic [16:0]          w_err_sum;
    logic                 w_unused_desc;

    // Only the low BUFID_W descriptor bits carry information.
    assign w_unused_desc = ^iv_descriptor[DESC_W-1:BUFID_W];

    assign w_ret_flag  = iv_pkt_rdata[DATA_W-1 -: 2];
    assign w_last_line = (w_ret_line == LINE_MAX);
    // Packet ends on a returned tail flag, or on the last addressable line
    // (which is then emitted as a forced tail).
    assign w_done      = w_ret_valid && ((w_ret_flag == FLAG_TAIL) || w_last_line);
    assign w_trunc     = w_ret_valid && (w_ret_flag != FLAG_TAIL) && w_last_line;

    // Reads stop the very cycle the end of packet comes back, and never
    // go past the last line.
    assign w_rd = (r_state == ST_READ) && !r_all_issued && !w_done;

    // The free-pulse cycle is still treated as busy for incoming descriptors.
    assign w_desc_take = i_descriptor_wr && (r_state == ST_IDLE) && !r_free;
    assign w_desc_drop = i_descriptor_wr && !w_desc_take;
    assign w_ack       = (r_state == ST_RELEASE) && i_pkt_bufid_ack;

    host_rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (LINE_W)
    ) u_rd_lat_pipe (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_issue      (w_rd),
        .iv_issue_tag (r_line),
        .i_flush      (w_done || (r_state != ST_READ)),
        .o_ret_valid  (w_ret_valid),
        .ov_ret_tag   (w_ret_line)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_desc_take) w_next_state = ST_READ;
            end
            ST_READ: begin
                if (w_done) w_next_state = (IFG_CYCLES == 0) ? ST_RELEASE : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_LAST)) w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_ack) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bufid      <= '0;
            r_line       <= '0;
            r_all_issued <= 1'b0;
            r_gap_cnt    <= '0;
            r_free       <= 1'b0;
            r_data       <= '0;
            r_data_wr    <= 1'b0;
            r_pkt_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_desc_take) begin
                r_bufid      <= iv_descriptor[BUFID_W-1:0];
                r_line       <= '0;
                r_all_issued <= 1'b0;
            end else if (w_rd) begin
                if (r_line == LINE_MAX) r_all_issued <= 1'b1;
                else                    r_line       <= r_line + 1'b1;
            end

            if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                   r_gap_cnt <= '0;

            r_data_wr <= w_ret_valid;
            if (w_ret_valid) begin
                r_data <= w_trunc ? {FLAG_TAIL, iv_pkt_rdata[DATA_W-3:0]} : iv_pkt_rdata;
            end

            r_free <= w_ack;
            if (w_ack) r_pkt_cnt <= r_pkt_cnt + 1'b1;

            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    // A drop and a truncation can land on the same cycle.
    assign w_err_inc = {1'b0, w_desc_drop} + {1'b0, w_trunc};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    assign o_pkt_rd            = w_rd;
    assign ov_pkt_raddr        = w_rd ? {r_bufid, r_line} : '0;
    assign ov_data             = r_data;
    assign o_data_wr           = r_data_wr;
    assign o_pkt_bufid_wr      = (r_state == ST_RELEASE);
    assign ov_pkt_bufid        = (r_state == ST_RELEASE) ? r_bufid : '0;
    assign o_host_outport_free = r_free;
    assign ov_hot_state        = r_state;
    assign ov_debug_pkt_cnt    = r_pkt_cnt;
    assign ov_debug_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_host_output_transmit.sv
// Bench for host_output_transmit: a packet RAM model with 2-cycle latency,
// directed packets, and a monitor that checks every host word, release
// request and free pulse against expectations queued by the stimulus.
module tb_host_output_transmit;
    import host_output_transmit_pkg::*;

    localparam int BUFID_W = 9;
    localparam int LINE_W  = 4;
    localparam int DATA_W  = 134;
    localparam int RD_LAT  = 2;
    localparam int IFG     = 3;
    localparam int AW      = BUFID_W + LINE_W;

    logic              i_clk;
    logic              i_rst_n;
    logic [12:0]       iv_descriptor;
    logic              i_descriptor_wr;
    logic              o_host_outport_free;
    logic [AW-1:0]     ov_pkt_raddr;
    logic              o_pkt_rd;
    logic [DATA_W-1:0] iv_pkt_rdata;
    logic [DATA_W-1:0] ov_data;
    logic              o_data_wr;
    logic [BUFID_W-1:0] ov_pkt_bufid;
    logic              o_pkt_bufid_wr;
    logic              i_pkt_bufid_ack;
    logic [1:0]        ov_hot_state;
    logic [15:0]       ov_debug_pkt_cnt;
    logic [15:0]       ov_debug_err_cnt;

    host_output_transmit #(
        .BUFID_W(BUFID_W), .LINE_W(LINE_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .IFG_CYCLES(IFG)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .iv_descriptor       (iv_descriptor),
        .i_descriptor_wr     (i_descriptor_wr),
        .o_host_outport_free (o_host_outport_free),
        .ov_pkt_raddr        (ov_pkt_raddr),
        .o_pkt_rd            (o_pkt_rd),
        .iv_pkt_rdata        (iv_pkt_rdata),
        .ov_data             (ov_data),
        .o_data_wr           (o_data_wr),
        .ov_pkt_bufid        (ov_pkt_bufid),
        .o_pkt_bufid_wr      (o_pkt_bufid_wr),
        .i_pkt_bufid_ack     (i_pkt_bufid_ack),
        .ov_hot_state        (ov_hot_state),
        .ov_debug_pkt_cnt    (ov_debug_pkt_cnt),
        .ov_debug_err_cnt    (ov_debug_err_cnt)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- packet RAM model ----------------
    int tail_line [512];
    int inv_line  [512];

    function automatic logic [DATA_W-1:0] mk_word(int b, int l);
        logic [1:0] f;
        if (l == tail_line[b])     f = FLAG_TAIL;
        else if (l == inv_line[b]) f = FLAG_INV;
        else if (l == 0)           f = FLAG_HEAD;
        else                       f = FLAG_MID;
        return {f, 4'(l), 16'(b), 16'(l), 96'h5A5A_1234_5678_9ABC_DEF0_F00D};
    endfunction

    logic          s1_vld, s2_vld;
    logic [AW-1:0] s1_addr, s2_addr;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0; s2_vld <= 1'b0; s1_addr <= '0; s2_addr <= '0;
        end else begin
            s1_vld <= o_pkt_rd; s1_addr <= ov_pkt_raddr;
            s2_vld <= s1_vld;   s2_addr <= s1_addr;
        end
    end
    always_comb begin
        iv_pkt_rdata = '0;
        if (s2_vld) iv_pkt_rdata = mk_word(int'(s2_addr[AW-1:LINE_W]), int'(s2_addr[LINE_W-1:0]));
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0]  exp_data_q[$];
    logic [BUFID_W-1:0] exp_rel_q[$];
    int                 exp_hold_q[$];
    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int free_cnt = 0;
    int desc_cyc = 0;
    bit first_pending = 0;

    task automatic chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor + release-ack responder ----------------
    initial begin
        int req_age = 0;
        int hold = 0;
        int last_data_cyc = 0;
        bit prev_wr = 0, prev_free = 0, prev_ack = 0;
        i_pkt_bufid_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                i_pkt_bufid_ack = 1'b0;
                req_age = 0; hold = 0;
                prev_wr = 0; prev_free = 0; prev_ack = 0;
            end else begin
                if (o_pkt_bufid_wr) begin
                    i_pkt_bufid_ack = (req_age == ack_delay);
                    req_age++;
                end else begin
                    i_pkt_bufid_ack = 1'b0;
                    req_age = 0;
                end

                if (o_data_wr) begin
                    if (exp_data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data_unexpected got %0h expected none", ov_data);
                    end else begin
                        chk("data", ov_data, exp_data_q.pop_front());
                    end
                    if (first_pending) begin
                        chk("first_word_latency", DATA_W'(cyc - desc_cyc), DATA_W'(RD_LAT + 2));
                        first_pending = 0;
                    end
                    last_data_cyc = cyc;
                end

                if (o_pkt_bufid_wr && !prev_wr) begin
                    if (exp_rel_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL release_unexpected got %0h expected none", ov_pkt_bufid);
                    end else begin
                        chk("release_bufid", DATA_W'(ov_pkt_bufid), DATA_W'(exp_rel_q.pop_front()));
                    end
                    chk("tail_to_release_gap", DATA_W'(cyc - last_data_cyc), DATA_W'(IFG));
                    hold = 0;
                end
                if (o_pkt_bufid_wr) hold++;
                if (!o_pkt_bufid_wr && prev_wr && exp_hold_q.size() != 0) begin
                    chk("release_hold", DATA_W'(hold), DATA_W'(exp_hold_q.pop_front()));
                end

                if (o_host_outport_free) begin
                    chk("free_width_1", DATA_W'(prev_free), DATA_W'(0));
                    chk("free_after_ack", DATA_W'(prev_ack), DATA_W'(1));
                    free_cnt++;
                end

                prev_wr   = o_pkt_bufid_wr;
                prev_free = o_host_outport_free;
                prev_ack  = o_pkt_bufid_wr && i_pkt_bufid_ack;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // tail < 0: packet has no tail flag in any of its 16 lines.
    task automatic load_pkt(int b, int tail, int inv);
        int n;
        logic [DATA_W-1:0] w;
        tail_line[b] = tail;
        inv_line[b]  = inv;
        n = (tail < 0) ? 16 : tail + 1;
        for (int l = 0; l < n; l++) begin
            w = mk_word(b, l);
            if (tail < 0 && l == 15) w[DATA_W-1 -: 2] = FLAG_TAIL;
            exp_data_q.push_back(w);
        end
        exp_rel_q.push_back(BUFID_W'(b));
        exp_hold_q.push_back(ack_delay + 1);
    endtask

    task automatic send_desc(logic [12:0] d, bit track);
        @(posedge i_clk); #1;
        iv_descriptor   = d;
        i_descriptor_wr = 1'b1;
        if (track) begin
            desc_cyc      = cyc;
            first_pending = 1;
        end
        @(posedge i_clk); #1;
        i_descriptor_wr = 1'b0;
        iv_descriptor   = '0;
    endtask

    task automatic wait_free(int budget);
        int start = free_cnt;
        int n = 0;
        while (free_cnt == start && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        checks++;
        if (free_cnt == start) begin
            errors++;
            $display("FAIL wait_free got no pulse expected one within %0d cycles", budget);
        end
        repeat (2) @(posedge i_clk);
    endtask

    task automatic chk_counts(string nm, int pkt, int err);
        @(negedge i_clk);
        chk({nm, "_pkt_cnt"}, DATA_W'(ov_debug_pkt_cnt), DATA_W'(pkt));
        chk({nm, "_err_cnt"}, DATA_W'(ov_debug_err_cnt), DATA_W'(err));
    endtask

    task automatic chk_idle_outputs(string nm);
        chk({nm, "_data"}, ov_data, '0);
        chk({nm, "_ctrl"},
            DATA_W'({o_pkt_rd, ov_pkt_raddr, o_data_wr, o_pkt_bufid_wr, ov_pkt_bufid,
                     o_host_outport_free, ov_hot_state, ov_debug_pkt_cnt, ov_debug_err_cnt}),
            '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 512; i++) begin
            tail_line[i] = -1;
            inv_line[i]  = -1;
        end
        i_rst_n         = 1'b0;
        iv_descriptor   = '0;
        i_descriptor_wr = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk_idle_outputs("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        // No free pulse may appear after reset.
        chk("no_free_after_reset", DATA_W'(free_cnt), DATA_W'(0));

        // 1: 3-line packet from bufid 5
        ack_delay = 0;
        load_pkt(5, 2, -1);
        send_desc(13'h005, 1);
        wait_free(200);
        chk_counts("pkt3", 1, 0);

        // 2: single-line packet; upper descriptor bits ignored (bufid 1)
        load_pkt(1, 0, -1);
        send_desc(13'h1E01, 1);
        wait_free(200);
        chk_counts("pkt1", 2, 0);

        // 3: no tail within 16 lines -> forced tail on line 15
        load_pkt(9'h1FF, -1, -1);
        send_desc(13'h01FF, 1);
        wait_free(300);
        chk_counts("trunc", 3, 1);

        // 4: bufid 3 (4 lines, line 1 flagged invalid), stray descriptor during READ
        load_pkt(3, 3, 1);
        send_desc(13'h003, 1);
        send_desc(13'h00A, 0);
        wait_free(200);
        chk_counts("busy_drop", 4, 2);

        // 5: release ack delayed 5 cycles -> request held 6 cycles
        ack_delay = 5;
        load_pkt(12, 1, -1);
        send_desc(13'h00C, 1);
        wait_free(200);
        chk_counts("ack_delay", 5, 2);
        ack_delay = 0;

        // 6: reset in the middle of READ, then a fresh packet
        load_pkt(7, 2, -1);
        send_desc(13'h007, 1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        exp_data_q.delete();
        exp_rel_q.delete();
        exp_hold_q.delete();
        first_pending = 0;
        @(negedge i_clk);
        chk_idle_outputs("mid_reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        load_pkt(32, 2, -1);
        send_desc(13'h020, 1);
        wait_free(200);
        chk_counts("after_reset", 1, 0);

        repeat (5) @(posedge i_clk);
        chk("data_queue_empty", DATA_W'(exp_data_q.size()), DATA_W'(0));
        chk("release_queue_empty", DATA_W'(exp_rel_q.size()), DATA_W'(0));
        chk("total_free_pulses", DATA_W'(free_cnt), DATA_W'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
